// File: rtl/lsu_mem_ctrl_if.sv
// Load/store unit bus bundle: pipeline request/response plus the
// word-wide data memory port driven by lsu_mem_ctrl.
interface lsu_mem_ctrl_if;
    logic        i_req;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rdata;
    logic [31:0] o_mem_addr;
    logic        o_mem_wren;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    modport master (
        output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
        input  o_ready, o_done, o_err, o_rdata,
        input  o_mem_addr, o_mem_wren, o_mem_wdata
    );

    modport slave (
        input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
        output o_ready, o_done, o_err, o_rdata,
        output o_mem_addr, o_mem_wren, o_mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// LSU memory controller: sized loads, word stores and read-modify-write
// sub-word stores against a word-addressed memory with combinational read.
module lsu_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    lsu_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    state_t      state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        wren_q;
    logic [31:0] maddr_q;
    logic [31:0] mwdata_q;

    logic        accept;
    logic [31:0] widx;
    logic        illegal;
    logic        misal;
    logic        oor;
    logic        err_d;
    logic        word_st;
    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] ld_d;
    logic [31:0] mask;
    logic [31:0] merge_d;

    assign accept  = bus.i_req && (state_q == IDLE);
    assign widx    = {2'b00, bus.i_addr[31:2]};
    assign oor     = widx >= DEPTH_L;
    assign err_d   = illegal | misal | oor;
    assign word_st = bus.i_we && (bus.i_funct3 == 3'b010);

    always_comb begin
        illegal = 1'b0;
        misal   = 1'b0;
        unique case (bus.i_funct3)
            3'b000: illegal = 1'b0;
            3'b001: misal   = bus.i_addr[0];
            3'b010: misal   = |bus.i_addr[1:0];
            3'b100: illegal = bus.i_we;
            3'b101: begin
                illegal = bus.i_we;
                misal   = bus.i_addr[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Lane select: shift the addressed byte/half down to bit 0
    assign sh   = {off_q, 3'b000};
    assign lane = bus.i_mem_rdata >> sh;

    always_comb begin
        ld_d = lane;
        unique case (f3_q)
            3'b000:  ld_d = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_d = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_d = {24'h0, lane[7:0]};
            3'b101:  ld_d = {16'h0, lane[15:0]};
            default: ld_d = lane;
        endcase
    end

    assign mask    = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    assign merge_d = (bus.i_mem_rdata & ~mask) | ((wdata_q << sh) & mask);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            wdata_q  <= 32'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            wren_q   <= 1'b0;
            maddr_q  <= 32'h0;
            mwdata_q <= 32'h0;
        end else begin
            done_q   <= 1'b0;
            wren_q   <= 1'b0;
            mwdata_q <= 32'h0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= bus.i_we;
                        f3_q    <= bus.i_funct3;
                        off_q   <= bus.i_addr[1:0];
                        wdata_q <= bus.i_wdata;
                        err_q   <= err_d;
                        rdata_q <= 32'h0;
                        if (err_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (word_st) begin
                            state_q  <= WR;
                            wren_q   <= 1'b1;
                            maddr_q  <= widx;
                            mwdata_q <= bus.i_wdata;
                        end else begin
                            state_q <= RD;
                            maddr_q <= widx;
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        state_q  <= WR;
                        wren_q   <= 1'b1;
                        mwdata_q <= merge_d;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        rdata_q <= ld_d;
                        maddr_q <= 32'h0;
                    end
                end
                WR: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    maddr_q <= 32'h0;
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Gate with reset so a reset landing in WR suppresses the write edge
    assign bus.o_mem_wren  = wren_q & i_rst_n;
    assign bus.o_ready     = (state_q == IDLE);
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_mem_addr  = maddr_q;
    assign bus.o_mem_wdata = mwdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against a byte-addressed memory model.
// Directed scenarios first, then random traffic.
module tb_lsu_mem_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   wr_total;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] mem [1024];
    logic [7:0]  rb  [4096];

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.DEPTH_WORDS(1024)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_mem_rdata = (bus.o_mem_addr < 32'd1024) ?
                             mem[bus.o_mem_addr[9:0]] : 32'h0;

    initial wr_total = 0;
    always @(posedge clk) begin
        if (bus.o_mem_wren) begin
            wr_total = wr_total + 1;
            wr_addr  = bus.o_mem_addr;
            wr_data  = bus.o_mem_wdata;
            if (bus.o_mem_addr < 32'd1024)
                mem[bus.o_mem_addr[9:0]] <= bus.o_mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refw(input int w);
        return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    endfunction

    task automatic do_op(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd);
        int size;
        int lat;
        int n;
        int w0;
        int e_lat;
        int e_wr;
        logic e_err;
        logic [31:0] e_rd;
        logic [31:0] val;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        e_err = (size == 0) || ((a % size) != 0) ||
                (we && f3[2]) || ((a / 4) >= 1024);
        e_rd = 32'h0;
        if (!e_err && !we) begin
            val = 32'h0;
            for (int i = 0; i < size; i++)
                val = val | (32'(rb[a + i]) << (8 * i));
            if (!f3[2] && size < 4 && val[8 * size - 1])
                val = val | ~((32'h1 << (8 * size)) - 1);
            e_rd = val;
        end
        if (!e_err && we)
            for (int i = 0; i < size; i++) rb[a + i] = wd[8 * i +: 8];
        e_lat = e_err ? 1 : (!we || size == 4) ? 2 : 3;
        e_wr  = (!e_err && we) ? 1 : 0;

        @(negedge clk);
        bus.i_req    = 1'b1;
        bus.i_we     = we;
        bus.i_funct3 = f3;
        bus.i_addr   = a;
        bus.i_wdata  = wd;
        n = 0;
        while (!bus.o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(n < 20), 32'd1);
        w0 = wr_total;
        @(posedge clk);
        #1;
        bus.i_req    = 1'b0;
        bus.i_we     = 1'($urandom);
        bus.i_funct3 = 3'($urandom);
        bus.i_addr   = $urandom;
        bus.i_wdata  = $urandom;
        chk("busy_ready", 32'(bus.o_ready), 32'd0);
        lat = 1;
        while (!bus.o_done && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, e_lat);
        chk("err", 32'(bus.o_err), 32'(e_err));
        chk("rdata", bus.o_rdata, e_rd);
        chk("done_addr", bus.o_mem_addr, 32'h0);
        chk("done_wren", 32'(bus.o_mem_wren), 32'd0);
        chk("wr_count", wr_total - w0, e_wr);
        if (e_wr == 1 && wr_total != w0)
            chk("wr_addr", wr_addr, a >> 2);
        if (!e_err && we)
            chk("mem_word", mem[a >> 2], refw(int'(a >> 2)));
        rd = bus.o_rdata;
        @(posedge clk);
        #1;
        chk("idle_ready", 32'(bus.o_ready), 32'd1);
        chk("done_pulse", 32'(bus.o_done), 32'd0);
        chk("rdata_hold", bus.o_rdata, e_rd);
        chk("err_hold", 32'(bus.o_err), 32'(e_err));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int w0;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.i_req    = 1'b0;
        bus.i_we     = 1'b0;
        bus.i_funct3 = 3'b000;
        bus.i_addr   = 32'h0;
        bus.i_wdata  = 32'h0;
        for (int i = 0; i < 4096; i++) rb[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_err", 32'(bus.o_err), 32'd0);
        chk("rst_rdata", bus.o_rdata, 32'h0);
        chk("rst_wren", 32'(bus.o_mem_wren), 32'd0);
        chk("rst_maddr", bus.o_mem_addr, 32'h0);
        chk("rst_mwdata", bus.o_mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", 32'(bus.o_ready), 32'd1);

        for (int w = 0; w < 32; w++)
            do_op(1'b1, 3'b010, 32'(w * 4), 32'h0, rd);

        do_op(1'b1, 3'b010, 32'h14, 32'h8899AABB, rd);
        do_op(1'b0, 3'b000, 32'h16, 32'h0, rd);
        chk("lb_0x16", rd, 32'hFFFFFF99);
        do_op(1'b0, 3'b101, 32'h16, 32'h0, rd);
        chk("lhu_0x16", rd, 32'h00008899);
        do_op(1'b0, 3'b100, 32'h14, 32'h0, rd);
        chk("lbu_0x14", rd, 32'h000000BB);
        do_op(1'b1, 3'b000, 32'h15, 32'h12345677, rd);
        chk("sb_merge", mem[5], 32'h889977BB);
        chk("sb_wdata", wr_data, 32'h889977BB);
        do_op(1'b0, 3'b010, 32'h102, 32'h0, rd);
        do_op(1'b1, 3'b001, 32'h3, 32'h1234, rd);
        do_op(1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, rd);
        do_op(1'b0, 3'b010, 32'hFFC, 32'h0, rd);
        do_op(1'b1, 3'b100, 32'h0, 32'h55, rd);
        do_op(1'b0, 3'b011, 32'h0, 32'h0, rd);
        do_op(1'b0, 3'b111, 32'h8, 32'h0, rd);

        // Reset landing in WR of a halfword store
        @(negedge clk);
        bus.i_req    = 1'b1;
        bus.i_we     = 1'b1;
        bus.i_funct3 = 3'b001;
        bus.i_addr   = 32'h22;
        bus.i_wdata  = 32'h0000BEEF;
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_wr", 32'(bus.o_mem_wren), 32'd1);
        w0    = wr_total;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_nowrite", wr_total - w0, 32'd0);
        chk("abort_wren", 32'(bus.o_mem_wren), 32'd0);
        chk("abort_done", 32'(bus.o_done), 32'd0);
        chk("abort_maddr", bus.o_mem_addr, 32'h0);
        chk("abort_mwdata", bus.o_mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", 32'(bus.o_ready), 32'd1);
        chk("abort_done2", 32'(bus.o_done), 32'd0);
        chk("abort_mem", mem[8], refw(8));

        // Held back-to-back: SW then LW with i_req never dropped
        @(negedge clk);
        bus.i_req    = 1'b1;
        bus.i_we     = 1'b1;
        bus.i_funct3 = 3'b010;
        bus.i_addr   = 32'h8;
        bus.i_wdata  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.i_we     = 1'b0;
        bus.i_addr   = 32'h8;
        bus.i_wdata  = 32'h0;
        {rb[11], rb[10], rb[9], rb[8]} = 32'hDEADBEEF;
        chk("b2b_busy", 32'(bus.o_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_sw_done", 32'(bus.o_done), 32'd1);
        chk("b2b_sw_rdata", bus.o_rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("b2b_idle", 32'(bus.o_ready), 32'd1);
        chk("b2b_nodone", 32'(bus.o_done), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_accept", 32'(bus.o_ready), 32'd0);
        bus.i_req = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_lw_done", 32'(bus.o_done), 32'd1);
        chk("b2b_lw_rdata", bus.o_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        for (int k = 0; k < 250; k++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom :
                32'($urandom_range(0, 127));
            do_op(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
